// File: rtl/ir_pkg.sv
// Shared types and NEC timing constants for the IR NEC transmitter.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    BIT_MARK   = 3'd3,
    BIT_SPACE  = 3'd4,
    STOP_MARK  = 3'd5,
    DONE       = 3'd6
  } ir_state_t;

  localparam int DEF_UNIT_CYCLES     = 28125;
  localparam int DEF_UNIT_CNT_WIDTH  = 15;

  localparam int NEC_LEAD_MARK_UNITS  = 16;
  localparam int NEC_LEAD_SPACE_UNITS = 8;
  localparam int NEC_REP_SPACE_UNITS  = 4;
  localparam int NEC_BIT_MARK_UNITS   = 1;
  localparam int NEC_ONE_SPACE_UNITS  = 3;
  localparam int NEC_ZERO_SPACE_UNITS = 1;
  localparam int NEC_STOP_MARK_UNITS  = 1;
  localparam int NEC_FRAME_BITS       = 32;

  // Frame payload in transmit order (LSB leaves first).
  function automatic logic [31:0] nec_payload(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

endpackage

// File: rtl/ir_unit_timer.sv
// Free-running NEC time-unit counter; unit_tick marks the last cycle of each unit.
module ir_unit_timer
  import ir_pkg::*;
#(
  parameter int UNIT_CYCLES = DEF_UNIT_CYCLES,
  parameter int CNT_WIDTH   = DEF_UNIT_CNT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic unit_tick
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(UNIT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt;

  assign unit_tick = (cnt == LAST);

  // In-unit cycle counter, restarted on every segment entry.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= {CNT_WIDTH{1'b0}};
    end else if (unit_tick) begin
      cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ir_nec_tx.sv
// NEC IR frame encoder: leader, 32 LSB-first data bits, stop mark, with carrier gating.
// The repeat request port is named repeat_frame because "repeat" is a reserved word.
module ir_nec_tx
  import ir_pkg::*;
#(
  parameter int UNIT_CYCLES      = DEF_UNIT_CYCLES,
  parameter int UNIT_CNT_WIDTH   = DEF_UNIT_CNT_WIDTH,
  parameter int LEAD_MARK_UNITS  = NEC_LEAD_MARK_UNITS,
  parameter int LEAD_SPACE_UNITS = NEC_LEAD_SPACE_UNITS,
  parameter int REP_SPACE_UNITS  = NEC_REP_SPACE_UNITS
) (
  input  logic       CLK_50M,
  input  logic       reset,
  input  logic       CLK_38K,
  input  logic       start,
  input  logic       repeat_frame,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       mark,
  output logic       ir_out
);

  ir_state_t   state, state_next;
  logic [31:0] shreg;
  logic        rep;
  logic [4:0]  bit_idx;
  logic [4:0]  units;
  logic [4:0]  seg_len;
  logic        seg_last;
  logic        unit_tick;
  logic        timer_clear;

  ir_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .CNT_WIDTH   (UNIT_CNT_WIDTH)
  ) u_timer (
    .clk       (CLK_50M),
    .reset     (reset),
    .clear     (timer_clear),
    .unit_tick (unit_tick)
  );

  // Segment length lookup and next-state decision.
  always_comb begin
    seg_len    = 5'(NEC_BIT_MARK_UNITS);
    state_next = state;
    case (state)
      LEAD_MARK:  seg_len = 5'(LEAD_MARK_UNITS);
      LEAD_SPACE: if (rep) seg_len = 5'(REP_SPACE_UNITS); else seg_len = 5'(LEAD_SPACE_UNITS);
      BIT_SPACE:  if (shreg[0]) seg_len = 5'(NEC_ONE_SPACE_UNITS); else seg_len = 5'(NEC_ZERO_SPACE_UNITS);
      STOP_MARK:  seg_len = 5'(NEC_STOP_MARK_UNITS);
      default:    seg_len = 5'(NEC_BIT_MARK_UNITS);
    endcase
    seg_last = unit_tick && (units == (seg_len - 5'd1));

    case (state)
      IDLE:       if (start) state_next = LEAD_MARK; else state_next = IDLE;
      LEAD_MARK:  if (seg_last) state_next = LEAD_SPACE; else state_next = LEAD_MARK;
      LEAD_SPACE: begin
        if (!seg_last)  state_next = LEAD_SPACE;
        else if (rep)   state_next = STOP_MARK;
        else            state_next = BIT_MARK;
      end
      BIT_MARK:   if (seg_last) state_next = BIT_SPACE; else state_next = BIT_MARK;
      BIT_SPACE: begin
        if (!seg_last)                                  state_next = BIT_SPACE;
        else if (bit_idx == 5'(NEC_FRAME_BITS - 1))     state_next = STOP_MARK;
        else                                            state_next = BIT_MARK;
      end
      STOP_MARK:  if (seg_last) state_next = DONE; else state_next = STOP_MARK;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase

    timer_clear = (state == IDLE) || (state_next != state);
  end

  // State, frame data and registered outputs.
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= 32'd0;
      rep     <= 1'b0;
      bit_idx <= 5'd0;
      units   <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mark    <= 1'b0;
      ir_out  <= 1'b0;
    end else begin
      state  <= state_next;
      busy   <= (state_next != IDLE) && (state_next != DONE);
      done   <= (state_next == DONE);
      mark   <= (state_next == LEAD_MARK) || (state_next == BIT_MARK) || (state_next == STOP_MARK);
      ir_out <= mark & CLK_38K;

      if (state == IDLE && start) begin
        shreg   <= nec_payload(addr, cmd);
        rep     <= repeat_frame;
        bit_idx <= 5'd0;
        units   <= 5'd0;
      end else if (seg_last) begin
        units <= 5'd0;
        if (state == BIT_SPACE) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 5'd1;
        end else begin
          bit_idx <= bit_idx;
        end
      end else if (unit_tick) begin
        units <= units + 5'd1;
      end else begin
        units <= units;
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Scoreboard bench for ir_nec_tx: expected mark/space segments queued at each start, checked as the envelope runs.
module tb_ir_nec_tx;

  localparam int U = 10;

  typedef struct {
    logic level;
    int   len;
  } seg_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk38 = 1'b0;
  logic       start;
  logic       repeat_frame;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       busy, done, mark, ir_out;

  int   n_checks = 0;
  int   n_errors = 0;
  seg_t exp_q[$];
  int   exp_busy_q[$];
  int   done_cnt = 0;
  bit   mon_en = 1'b0;
  bit   aborting = 1'b0;
  int   c_div = 0;

  logic p_busy = 1'b0, p_mark = 1'b0, p_c38 = 1'b0, p_reset = 1'b1;
  logic cur = 1'b0;
  int   run = 0;
  int   busy_len = 0;

  ir_nec_tx #(.UNIT_CYCLES(U), .UNIT_CNT_WIDTH(15)) dut (
    .CLK_50M      (clk),
    .reset        (reset),
    .CLK_38K      (clk38),
    .start        (start),
    .repeat_frame (repeat_frame),
    .addr         (addr),
    .cmd          (cmd),
    .busy         (busy),
    .done         (done),
    .mark         (mark),
    .ir_out       (ir_out)
  );

  always #5 clk = ~clk;

  // Carrier stand-in: toggles every 3 clock cycles, changed just after the rising edge.
  always begin
    @(posedge clk);
    #2;
    if (c_div == 2) begin
      c_div = 0;
      clk38 = ~clk38;
    end else begin
      c_div = c_div + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic close_run();
    seg_t e;
    if (exp_q.size() == 0) begin
      chk("extra_segment", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("seg_level", {31'd0, cur}, {31'd0, e.level});
      chk("seg_len", run, e.len);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] c, input logic r);
    logic [31:0] p;
    int units;
    p = {~c, c, ~a, a};
    exp_q.push_back('{1'b1, 16 * U});
    units = 16;
    if (r) begin
      exp_q.push_back('{1'b0, 4 * U});
      exp_q.push_back('{1'b1, U});
      units += 5;
    end else begin
      exp_q.push_back('{1'b0, 8 * U});
      units += 8;
      for (int i = 0; i < 32; i++) begin
        exp_q.push_back('{1'b1, U});
        exp_q.push_back('{1'b0, p[i] ? 3 * U : U});
        units += p[i] ? 4 : 2;
      end
      exp_q.push_back('{1'b1, U});
      units += 1;
    end
    exp_busy_q.push_back(units * U);
    addr = a; cmd = c; repeat_frame = r; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 3000 && done_cnt == d0; i++) tick();
    chk({tag, "_timeout"}, 32'(done_cnt - d0), 32'd1);
    repeat (20) tick();
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; repeat_frame = 1'b0; addr = 8'h00; cmd = 8'h00;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mark", {31'd0, mark}, 32'd0);
    chk("rst_ir_out", {31'd0, ir_out}, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          if (!p_reset) chk("ir_out_gate", {31'd0, ir_out}, {31'd0, p_mark & p_c38});
          if (!busy && !done) chk("idle_ir_out", {31'd0, ir_out}, 32'd0);
          if (busy) begin
            if (!p_busy) begin
              cur = mark; run = 1; busy_len = 1;
            end else begin
              busy_len++;
              if (mark === cur) run++;
              else begin
                close_run();
                cur = mark; run = 1;
              end
            end
          end else if (p_busy) begin
            if (aborting) begin
              chk("abort_no_done", {31'd0, done}, 32'd0);
            end else begin
              close_run();
              chk("done_at_end", {31'd0, done}, 32'd1);
              if (exp_busy_q.size() == 0) chk("extra_frame", 32'd1, 32'd0);
              else chk("busy_len", busy_len, exp_busy_q.pop_front());
            end
          end
          if (done) done_cnt++;
        end
        p_busy = busy; p_mark = mark; p_c38 = clk38; p_reset = reset;
      end
    join_none

    // Data frame with one address/command of each polarity.
    send(8'h00, 8'hFF, 1'b0);
    wait_done("data_00_ff");

    // Repeat code: data bytes must not matter.
    send(8'hAA, 8'h55, 1'b1);
    wait_done("repeat");

    // Start with new data mid-frame must be ignored.
    send(8'h5A, 8'h3C, 1'b0);
    repeat (498) tick();
    addr = 8'h12; cmd = 8'h34; repeat_frame = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("start_busy");

    // Reset mid-frame abandons the frame without done.
    send(8'hC3, 8'h81, 1'b0);
    repeat (698) tick();
    aborting = 1'b1;
    reset = 1'b1;
    tick();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_mark", {31'd0, mark}, 32'd0);
    chk("midrst_ir_out", {31'd0, ir_out}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_busy_q.delete();
    repeat (5) tick();
    aborting = 1'b0;
    chk("midrst_idle_busy", {31'd0, busy}, 32'd0);

    // Fresh frame after the abort runs to completion.
    send(8'h01, 8'h80, 1'b0);
    wait_done("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
